queue: RTL and testbench
========================

QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 push  input  1  enqueue request; writes rear at the rising edge when accepted.
REQ-006 pop  input  1  dequeue request; removes head entry at the rising edge when accepted.
REQ-007 rear  input  WIDTH  data to enqueue.
REQ-008 front  output  WIDTH  data of the oldest entry (head).
REQ-009 empty  output  1  high when the queue holds 0 entries.
REQ-010 full  output  1  high when the queue holds DEPTH entries.

Function
REQ-011 Queue SHALL be FIFO-ordered: entries leave in the order they were accepted.
REQ-012 Push SHALL be accepted when push=1 and full=0; rear is written at the tail and the tail pointer advances.
REQ-013 Pop SHALL be accepted when pop=1 and empty=0; the head pointer advances.
REQ-014 Push while full (without accepted pop) SHALL be ignored; contents, pointers and flags unchanged.
REQ-015 Pop while empty SHALL be ignored; no underflow, pointers and flags unchanged.
REQ-016 Simultaneous push and pop when not empty SHALL both take effect; occupancy unchanged, including when full.
REQ-017 Simultaneous push and pop when empty SHALL perform the push only.
REQ-018 front SHALL be first-word-fall-through: combinationally equals the head entry, valid in the same cycle empty=0, zero latency after the accepting edge.
REQ-019 front SHALL be 0 while empty=1.
REQ-020 empty and full SHALL be registered-state-derived (occupancy count or pointer compare), updated at the same edge as the accepted operation.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-022 Occupancy SHALL use a counter of clog2(DEPTH)+1 bits; no arithmetic overflow possible.

Reset
REQ-023 While rst=0, head, tail and occupancy SHALL clear immediately (asynchronously): empty=1, full=0, front=0.
REQ-024 Storage array SHALL NOT require reset; contents are discarded by reset.
REQ-025 Reset asserted mid-operation SHALL abort any in-flight push/pop; after release the queue is empty.
REQ-026 push/pop SHALL take effect only on rising edges after rst returns to 1.

Structure
REQ-027 Default WIDTH/DEPTH constants SHALL live in the shared project package; no typedefs required.
REQ-028 Single module with an internal register-array; no sub-module required.

Verification
REQ-029 Reset held 2 clocks, release, idle cycle -> empty=1, full=0, front=0.
REQ-030 push=1 with rear=0x12345 for one edge -> empty=0, front=0x12345; then idle edge -> state unchanged.
REQ-031 Push 1..10 on 10 consecutive edges, then pop 11 times -> front sequence 0x12345,1,2,...,10, empty=1 after 11th pop.
REQ-032 Extra pop while empty -> empty stays 1, front=0, no pointer change (next push then reads back correctly).
REQ-033 Push DEPTH values -> full=1 after DEPTH-th edge; further push ignored; push+pop together while full -> full stays 1, order preserved.
REQ-034 Fill/drain repeatedly across 3*DEPTH operations with rst pulsed low mid-stream -> wrap-around order correct, reset empties queue asynchronously.

Source files
------------

// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_pkg
// Description : Shared project constants for the FIFO queue block.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_pkg;

    // Default data word width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Default number of storage entries (power of two, at least 2).
    localparam int DEFAULT_DEPTH = 16;

endpackage : queue_pkg
`default_nettype wire

// File: rtl/queue.sv
`default_nettype none
// ============================================================================
// Module      : queue
// Description : Single-clock first-word-fall-through FIFO queue. Storage is a
//               register array addressed by wrapping head/tail pointers; an
//               occupancy counter provides the empty/full flags. front shows
//               the head entry combinationally and reads 0 while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module queue
    import queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] rear,
    output logic [WIDTH-1:0] front,
    output logic             empty,
    output logic             full
);

    // Pointer width addresses DEPTH entries; the counter needs one more bit
    // so that the value DEPTH itself is representable.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered occupancy count.
    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);

    // A pop is only honoured when there is something to remove. A push is
    // honoured when there is room, or when full but a pop frees a slot in
    // the same edge (full implies non-empty, so that pop is always taken).
    // On an empty queue a simultaneous pop is dropped and only the push lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // First-word-fall-through output, forced to zero while nothing is held.
    assign front = empty ? '0 : mem[head];

    // Storage write; no reset needed since reset discards contents via the
    // pointers and counter.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= rear;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap
    // naturally from DEPTH-1 to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule : queue
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue
// Description : Self-checking bench for the queue block: a directed vector
//               table for the basic flow plus hand-written sequences for
//               fill/full, wrap-around and asynchronous mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rear;
    logic [WIDTH-1:0] front;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;

    // Reference contents for the multi-cycle sequences.
    logic [WIDTH-1:0] model_q [$];

    typedef struct {
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] rear;
        logic             exp_empty;
        logic             exp_full;
        logic [WIDTH-1:0] exp_front;
    } vec_t;

    vec_t vecs [$];

    queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .rear  (rear),
        .front (front),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic p, input logic q, input logic [WIDTH-1:0] d,
                           input logic e, input logic f, input logic [WIDTH-1:0] fr);
        vec_t v;
        v.push = p; v.pop = q; v.rear = d;
        v.exp_empty = e; v.exp_full = f; v.exp_front = fr;
        vecs.push_back(v);
    endtask

    // Compare outputs against the reference model contents.
    task automatic chk_model(input string name);
        logic [WIDTH-1:0] ef;
        ef = (model_q.size() == 0) ? '0 : model_q[0];
        chk({name, "_empty"}, WIDTH'(empty), WIDTH'(model_q.size() == 0));
        chk({name, "_full"},  WIDTH'(full),  WIDTH'(model_q.size() == DEPTH));
        chk({name, "_front"}, front, ef);
    endtask

    // One clocked operation with the reference model updated at the edge.
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input string name);
        bit do_pop;
        bit do_push;
        push = p; pop = q; rear = d;
        @(posedge clk);
        do_pop  = q && (model_q.size() > 0);
        do_push = p && ((model_q.size() < DEPTH) || do_pop);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        #1;
        chk_model(name);
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; rear = '0;
        rst  = 1'b1;
        #2 rst = 1'b0;
        #1;
        // Reset takes effect before any clock edge.
        chk("async_rst_empty", WIDTH'(empty), WIDTH'(1));
        chk("async_rst_full",  WIDTH'(full),  WIDTH'(0));
        chk("async_rst_front", front, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_empty", WIDTH'(empty), WIDTH'(1));
        chk("reset_full",  WIDTH'(full),  WIDTH'(0));
        chk("reset_front", front, '0);

        // ---------------- directed vector table ----------------
        add_vec(1, 0, 32'h12345, 0, 0, 32'h12345);          // first push
        add_vec(0, 0, 32'h0,     0, 0, 32'h12345);          // idle holds state
        for (int k = 1; k <= 10; k++)
            add_vec(1, 0, WIDTH'(k), 0, 0, 32'h12345);      // push 1..10
        for (int k = 1; k <= 10; k++)
            add_vec(0, 1, 32'h0, 0, 0, WIDTH'(k));          // pops expose 1..10
        add_vec(0, 1, 32'h0,  1, 0, 32'h0);                 // 11th pop empties
        add_vec(0, 1, 32'h0,  1, 0, 32'h0);                 // pop while empty ignored
        add_vec(1, 1, 32'hAB, 0, 0, 32'hAB);                // push+pop on empty: push only
        add_vec(1, 0, 32'hCD, 0, 0, 32'hAB);
        add_vec(1, 1, 32'hEF, 0, 0, 32'hCD);                // push+pop non-empty
        add_vec(0, 1, 32'h0,  1, 0, 32'h0);                 // pop last entry? no: EF remains
        // Correct the last vector: after popping CD, EF is still held.
        vecs[vecs.size()-1].exp_empty = 0;
        vecs[vecs.size()-1].exp_front = 32'hEF;
        add_vec(0, 1, 32'h0,  1, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            push = vecs[i].push; pop = vecs[i].pop; rear = vecs[i].rear;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_empty", i), WIDTH'(empty), WIDTH'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full",  i), WIDTH'(full),  WIDTH'(vecs[i].exp_full));
            chk($sformatf("vec%0d_front", i), front, vecs[i].exp_front);
        end
        push = 1'b0; pop = 1'b0;

        // ---------------- fill to full ----------------
        model_q.delete();
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, WIDTH'(32'h100 + i), $sformatf("fill%0d", i));
        chk("full_after_depth", WIDTH'(full), WIDTH'(1));
        step(1, 0, 32'hDEAD, "push_when_full");
        chk("push_full_front", front, 32'h100);
        step(1, 1, 32'hBEEF, "pushpop_full");
        chk("pushpop_full_flag", WIDTH'(full), WIDTH'(1));
        chk("pushpop_full_front", front, 32'h101);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, '0, $sformatf("drain%0d", i));
        chk("drain_empty", WIDTH'(empty), WIDTH'(1));

        // ---------------- wrap-around with mid-stream reset ----------------
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (i == 20) begin
                #2 rst = 1'b0;
                #1;
                chk("mid_rst_empty", WIDTH'(empty), WIDTH'(1));
                chk("mid_rst_full",  WIDTH'(full),  WIDTH'(0));
                chk("mid_rst_front", front, '0);
                model_q.delete();
                push = 1'b1; pop = 1'b0; rear = 32'h5555;
                @(posedge clk); #1;
                chk("push_in_rst_ignored", WIDTH'(empty), WIDTH'(1));
                @(negedge clk) rst = 1'b1;
            end
            // Mostly pushes early, mostly pops late, mixing both to wrap.
            step((i % 4) != 3 || i < 12, (i % 3) == 2 || i >= 36,
                 WIDTH'(32'h2000 + i), $sformatf("wrap%0d", i));
        end
        while (model_q.size() > 0)
            step(0, 1, '0, "final_drain");
        chk("final_empty", WIDTH'(empty), WIDTH'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_queue
`default_nettype wire
